debounce_edge: RTL and testbench
================================

# debounce_edge

Synchronises and debounces one raw asynchronous level input (switch or button) into a clean registered level. Also produces single-cycle rising and falling edge strobes and a toggle output. Sits directly upstream of the team's d_ff/t_ff storage stages: its `q`, `rise` or `tq` drives their `d` input, so those stages only ever see glitch-free, clock-aligned data.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `d`; legal values ≥ 2.
- `STABLE_CYCLES`, default 8: consecutive enabled samples of a new level required before `q` changes; legal range 1 … 2^CNT_W−1.
- `CNT_W`, default 4: width of the stability counter.
- `clk` input, 1: single clock, all logic on its rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `d` input, 1: raw asynchronous level.
- `en` input, 1: sample enable; the state machine advances only when `en`=1.
- `q` output, 1: debounced level, registered.
- `rise` output, 1: one-cycle strobe, high in the cycle in which `q` goes 0→1.
- `fall` output, 1: one-cycle strobe, high in the cycle in which `q` goes 1→0.
- `tq` output, 1: toggles on every `rise`, registered.
- `busy` output, 1: high while a candidate level change is being qualified (WAIT states).

## Operation
- **Synchroniser:** a chain of `SYNC_STAGES` flops clocked every cycle regardless of `en`. The last stage is `s`. No other logic samples `d` directly.
- **FSM states:** `LO` (`q`=0), `WAIT_HI`, `HI` (`q`=1), `WAIT_LO`. Counter `cnt` is `CNT_W` bits.
- **When `en`=1:**
  - `LO`: if `s`=1, go to `WAIT_HI` with `cnt`=1; if `STABLE_CYCLES`=1, go directly to `HI` instead.
  - `WAIT_HI`: if `s`=0, go to `LO` with `cnt`=0. Else if `cnt`=`STABLE_CYCLES`−1, go to `HI` and assert `q`=1, `rise`=1, `tq`=~`tq`. Else `cnt`++.
  - `HI` and `WAIT_LO` are the mirror image, using `s`=0, `fall` and `q`=0. `tq` is unchanged on a fall.
- **When `en`=0:** state, `cnt`, `q` and `tq` hold; `rise`=`fall`=0.
- `busy` is 1 exactly when the state is `WAIT_HI` or `WAIT_LO`.
- `cnt` never wraps. It is cleared on every return to a stable state and saturates by construction at `STABLE_CYCLES`−1.
- `rise` and `fall` are never high in the same cycle, and each is never high for two consecutive cycles.

## Timing
- **Reset values** (`rst`=1 at a clock edge): synchroniser flops 0, state `LO`, `cnt`=0, `q`=0, `rise`=0, `fall`=0, `tq`=0, `busy`=0.
- `rst` has priority over `en` and `d`.
- **Reset mid-operation:** `q` drops to 0 at the reset edge with no `fall` strobe. A pending qualification is discarded.
- **After reset release with `d` held 1:** a normal `rise` sequence follows.
- **Latency** with `en`=1 throughout: count the first edge that samples the new `d` as edge 1. `q`/`rise`/`fall` update at edge `SYNC_STAGES`+`STABLE_CYCLES`. With defaults this is edge 10.
- **`busy` timing:** `busy` rises at edge `SYNC_STAGES`+1 and falls together with the `q` update.
- **Aborted change:** any return of `s` to the current `q` level during WAIT aborts the change, so a new qualification restarts from 1.
- **Enable gating:** with `en` toggling, latency counts enabled samples only. Cycles with `en`=0 neither advance nor abort a qualification.
- All outputs are registered or decoded from registered state only; there is no combinational path from `d`, `en` or `rst` to any output.

## Test plan
Defaults apply throughout: `SYNC_STAGES`=2, `STABLE_CYCLES`=8, `CNT_W`=4.
- **Reset:** `rst`=1 for 3 cycles with `d`=1, `en`=1 → `q`, `rise`, `fall`, `tq`, `busy` all 0 during reset. After release, `q`=1 with `rise`=1 exactly at edge 10, then `tq`=1.
- **Clean edges:** `d` 0→1, held 20 cycles → `busy`=1 from edge 3, and `q`=1 with a single-cycle `rise` at edge 10. Then `d`→0 → `fall` pulse and `q`=0 at edge 10, with `tq` unchanged.
- **Bounce:** `d` toggles every 3 cycles for 30 cycles, then holds 1 → `q` stays 0 and no strobes during the bounce. `q`=1 at edge 10 after the final 0→1 sample, with exactly one `rise`.
- **Short glitch:** `d`=1 for 7 cycles, then 0 → `busy` pulses, `q` stays 0, no `rise`. With `d`=1 for exactly 8 cycles → `q`=1 and one `rise`.
- **Enable gating:** `d`=1 with `en` alternating 1/0 → `q` rises after 8 enabled samples (the update lands on an enabled edge). With `en`=0 held throughout, `q` never changes.
- **Reset mid-operation:** with `q`=1, assert `rst` for 1 cycle while `d`=1 → `q`=0 at that edge with no `fall`, `tq`=0. `q` re-rises with `rise` 10 edges after release.

Source files
------------

// File: rtl/debounce_edge_if.sv
// rtl/debounce_edge_if.sv - raw level in, debounced level/strobes/toggle out
interface debounce_edge_if;
    logic d;
    logic en;
    logic q;
    logic rise;
    logic fall;
    logic tq;
    logic busy;

    modport master (
        output d,
        output en,
        input  q,
        input  rise,
        input  fall,
        input  tq,
        input  busy
    );

    modport slave (
        input  d,
        input  en,
        output q,
        output rise,
        output fall,
        output tq,
        output busy
    );
endinterface

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronise and debounce one raw level, with edge strobes and toggle
module debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
    debounce_edge_if.slave  bus
);
    typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   q_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   tq_r;

    // Free-running synchroniser: the only logic that ever looks at the raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.d};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LO;
            cnt    <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            tq_r   <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (bus.en) begin
                case (state)
                    LO: begin
                        if (s) begin
                            if (STABLE_CYCLES == 1) begin
                                state  <= HI;
                                q_r    <= 1'b1;
                                rise_r <= 1'b1;
                                tq_r   <= ~tq_r;
                            end else begin
                                state <= WAIT_HI;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state <= LO;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= HI;
                            cnt    <= '0;
                            q_r    <= 1'b1;
                            rise_r <= 1'b1;
                            tq_r   <= ~tq_r;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HI: begin
                        if (!s) begin
                            if (STABLE_CYCLES == 1) begin
                                state  <= LO;
                                q_r    <= 1'b0;
                                fall_r <= 1'b1;
                            end else begin
                                state <= WAIT_LO;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state <= HI;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= LO;
                            cnt    <= '0;
                            q_r    <= 1'b0;
                            fall_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= LO;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.tq   = tq_r;
    assign bus.busy = (state == WAIT_HI) || (state == WAIT_LO);
endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - directed self-checking bench for debounce_edge
module tb_debounce_edge;
    logic clk = 1'b0;
    logic rst = 1'b1;

    debounce_edge_if bus_if ();

    debounce_edge #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .CNT_W         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n, rise_edge, fall_edge, busy_edge, n_rise, n_fall, n_both;
    bit en_alt = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_track();
        edge_n = 0; rise_edge = 0; fall_edge = 0; busy_edge = 0;
        n_rise = 0; n_fall = 0;
    endtask

    // Edge numbering restarts at clear_track; edge 1 is the first edge after it.
    task automatic track(input int n);
        for (int i = 0; i < n; i++) begin
            if (en_alt) bus_if.en = ((edge_n + 1) % 2 == 1);
            step();
            edge_n++;
            if (bus_if.rise === 1'b1) begin
                n_rise++;
                if (rise_edge == 0) rise_edge = edge_n;
            end
            if (bus_if.fall === 1'b1) begin
                n_fall++;
                if (fall_edge == 0) fall_edge = edge_n;
            end
            if (bus_if.busy === 1'b1 && busy_edge == 0) busy_edge = edge_n;
            if (bus_if.rise === 1'b1 && bus_if.fall === 1'b1) n_both++;
        end
    endtask

    initial begin
        n_both = 0;
        bus_if.d  = 1'b1;
        bus_if.en = 1'b1;
        rst = 1'b1;

        // Reset with d=1, then a normal rise after release
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", {bus_if.q, bus_if.rise, bus_if.fall, bus_if.tq, bus_if.busy}, 0);
        end
        rst = 1'b0;
        clear_track();
        track(9);
        check("rst_rel_q_e9", bus_if.q, 0);
        track(1);
        check("rst_rel_rise_e10", bus_if.rise, 1);
        check("rst_rel_q_e10", bus_if.q, 1);
        check("rst_rel_tq_e10", bus_if.tq, 1);
        track(1);
        check("rst_rel_rise_e11", bus_if.rise, 0);
        check("rst_rel_busy_edge", busy_edge, 3);

        // Clean fall, rise, fall
        bus_if.d = 1'b0;
        clear_track();
        track(20);
        check("clean_fall_edge", fall_edge, 10);
        check("clean_fall_busy_edge", busy_edge, 3);
        check("clean_fall_n", n_fall, 1);
        check("clean_fall_tq", bus_if.tq, 1);
        check("clean_fall_q", bus_if.q, 0);

        bus_if.d = 1'b1;
        clear_track();
        track(20);
        check("clean_rise_edge", rise_edge, 10);
        check("clean_rise_busy_edge", busy_edge, 3);
        check("clean_rise_n", n_rise, 1);
        check("clean_rise_tq", bus_if.tq, 0);
        check("clean_rise_busy_end", bus_if.busy, 0);

        bus_if.d = 1'b0;
        clear_track();
        track(20);
        check("clean_fall2_edge", fall_edge, 10);
        check("clean_fall2_tq", bus_if.tq, 0);
        check("clean_fall2_nrise", n_rise, 0);

        // Bounce: 3-cycle runs never qualify
        clear_track();
        for (int i = 0; i < 10; i++) begin
            bus_if.d = (i % 2 == 0);
            track(3);
        end
        check("bounce_nrise", n_rise, 0);
        check("bounce_nfall", n_fall, 0);
        check("bounce_q", bus_if.q, 0);
        check("bounce_busy_edge", busy_edge, 3);
        bus_if.d = 1'b1;
        clear_track();
        track(20);
        check("bounce_final_rise_edge", rise_edge, 10);
        check("bounce_final_nrise", n_rise, 1);
        check("bounce_final_tq", bus_if.tq, 1);

        bus_if.d = 1'b0;
        clear_track();
        track(20);
        check("pre_glitch_q", bus_if.q, 0);

        // Short glitch: 7 cycles aborts, 8 cycles qualifies
        clear_track();
        track(7);
        bus_if.d = 1'b0;
        clear_track();
        bus_if.d = 1'b1;
        track(7);
        bus_if.d = 1'b0;
        track(20);
        check("glitch7_busy_edge", busy_edge, 3);
        check("glitch7_nrise", n_rise, 0);
        check("glitch7_q", bus_if.q, 0);
        check("glitch7_busy_end", bus_if.busy, 0);

        clear_track();
        bus_if.d = 1'b1;
        track(8);
        bus_if.d = 1'b0;
        track(20);
        check("glitch8_rise_edge", rise_edge, 10);
        check("glitch8_nrise", n_rise, 1);
        check("glitch8_fall_edge", fall_edge, 18);
        check("glitch8_tq", bus_if.tq, 0);

        // Enable gating: en on odd edges only
        en_alt = 1'b1;
        bus_if.d = 1'b1;
        clear_track();
        track(30);
        en_alt = 1'b0;
        check("en_alt_rise_edge", rise_edge, 17);
        check("en_alt_nrise", n_rise, 1);
        check("en_alt_q", bus_if.q, 1);
        check("en_alt_tq", bus_if.tq, 1);

        bus_if.en = 1'b0;
        bus_if.d = 1'b0;
        clear_track();
        track(40);
        check("en_off_nfall", n_fall, 0);
        check("en_off_q", bus_if.q, 1);
        check("en_off_busy_edge", busy_edge, 0);

        // Reset mid-operation with q=1
        bus_if.d = 1'b1;
        track(5);
        bus_if.en = 1'b1;
        track(5);
        check("mid_pre_q", bus_if.q, 1);
        rst = 1'b1;
        step();
        check("mid_rst_q", bus_if.q, 0);
        check("mid_rst_fall", bus_if.fall, 0);
        check("mid_rst_tq", bus_if.tq, 0);
        rst = 1'b0;
        clear_track();
        track(15);
        check("mid_rerise_edge", rise_edge, 10);
        check("mid_rerise_nfall", n_fall, 0);
        check("mid_rerise_nrise", n_rise, 1);

        check("rise_fall_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
